// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and the coordinate type used by the timing generator.
package vga_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned FCOUNT_W = 16;

   typedef logic [COORD_W-1:0] coord_t;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

endpackage

// File: rtl/sync_delay.sv
// Enable-gated shift register of DEPTH stages with a per-instance reset value; DEPTH=0 is a wire.
module sync_delay #(
   parameter int unsigned DEPTH   = 1,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic d,
   output logic q
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, en};
      assign q = d;
   end else begin : g_pipe
      logic [DEPTH-1:0] pipe_q;
      logic [DEPTH-1:0] pipe_d;

      always_comb begin
         pipe_d = pipe_q;
         if (en) begin
            pipe_d[0] = d;
            for (int i = 1; i < int'(DEPTH); i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pipe_q <= {DEPTH{RST_VAL}};
         end else begin
            pipe_q <= pipe_d;
         end
      end

      assign q = pipe_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync and blank decodes delayed to match the pixel pipeline.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned H_FP       = H_FP_DEF,
   parameter int unsigned H_SYNC     = H_SYNC_DEF,
   parameter int unsigned H_BP       = H_BP_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned V_FP       = V_FP_DEF,
   parameter int unsigned V_SYNC     = V_SYNC_DEF,
   parameter int unsigned V_BP       = V_BP_DEF,
   parameter int unsigned PIPE_DELAY = 1
) (
   input  logic                vga_clk,
   input  logic                reset_n,
   input  logic                pix_ce,
   output logic [COORD_W-1:0]  DrawX,
   output logic [COORD_W-1:0]  DrawY,
   output logic                hs,
   output logic                vs,
   output logic                active_nblank,
   output logic                frame_start,
   output logic [FCOUNT_W-1:0] frame_count
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   coord_t               x_q, x_d;
   coord_t               y_q, y_d;
   logic [FCOUNT_W-1:0]  fc_q, fc_d;
   logic                 hs_raw, vs_raw, act_raw;

   // Raster counters advance only on enabled pixels; frame count bumps on the last pixel of a frame.
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      fc_d = fc_q;
      if (pix_ce) begin
         if (x_q == coord_t'(H_TOTAL - 1)) begin
            x_d = '0;
            if (y_q == coord_t'(V_TOTAL - 1)) begin
               y_d  = '0;
               fc_d = FCOUNT_W'(fc_q + FCOUNT_W'(1));
            end else begin
               y_d = coord_t'(y_q + coord_t'(1));
            end
         end else begin
            x_d = coord_t'(x_q + coord_t'(1));
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q  <= '0;
         y_q  <= '0;
         fc_q <= '0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         fc_q <= fc_d;
      end
   end

   always_comb begin
      hs_raw  = !((x_q >= coord_t'(H_ACTIVE + H_FP)) &&
                  (x_q <  coord_t'(H_ACTIVE + H_FP + H_SYNC)));
      vs_raw  = !((y_q >= coord_t'(V_ACTIVE + V_FP)) &&
                  (y_q <  coord_t'(V_ACTIVE + V_FP + V_SYNC)));
      act_raw = (x_q < coord_t'(H_ACTIVE)) && (y_q < coord_t'(V_ACTIVE));
   end

   sync_delay #(.DEPTH(PIPE_DELAY), .RST_VAL(1'b1)) u_hs_dly (
      .clk(vga_clk), .rst_n(reset_n), .en(pix_ce), .d(hs_raw), .q(hs)
   );

   sync_delay #(.DEPTH(PIPE_DELAY), .RST_VAL(1'b1)) u_vs_dly (
      .clk(vga_clk), .rst_n(reset_n), .en(pix_ce), .d(vs_raw), .q(vs)
   );

   sync_delay #(.DEPTH(PIPE_DELAY), .RST_VAL(1'b0)) u_act_dly (
      .clk(vga_clk), .rst_n(reset_n), .en(pix_ce), .d(act_raw), .q(active_nblank)
   );

   assign frame_start = (x_q == '0) && (y_q == '0) && pix_ce;
   assign DrawX       = x_q;
   assign DrawY       = y_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default 640x480 instance (delay 1) plus two reduced-raster instances (delay 3 and 0).
module tb_vga_timing_gen;

   localparam int SH_A = 4, SH_F = 1, SH_S = 2, SH_B = 1;
   localparam int SV_A = 3, SV_F = 1, SV_S = 1, SV_B = 1;

   typedef struct {
      int x; int y; int hs; int vs; int act; int fs; int fc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pix_ce;

   logic [9:0]  def_x, def_y, d3_x, d3_y, d0_x, d0_y;
   logic        def_hs, def_vs, def_act, def_fs;
   logic        d3_hs, d3_vs, d3_act, d3_fs;
   logic        d0_hs, d0_vs, d0_act, d0_fs;
   logic [15:0] def_fc, d3_fc, d0_fc;

   int checks   = 0;
   int failures = 0;
   int k        = 0;

   exp_t q_def[$];
   exp_t q_d3[$];
   exp_t q_d0[$];

   always #5 clk = ~clk;

   vga_timing_gen u_def (
      .vga_clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
      .DrawX(def_x), .DrawY(def_y), .hs(def_hs), .vs(def_vs),
      .active_nblank(def_act), .frame_start(def_fs), .frame_count(def_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
      .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .PIPE_DELAY(3)
   ) u_d3 (
      .vga_clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
      .DrawX(d3_x), .DrawY(d3_y), .hs(d3_hs), .vs(d3_vs),
      .active_nblank(d3_act), .frame_start(d3_fs), .frame_count(d3_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
      .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .PIPE_DELAY(0)
   ) u_d0 (
      .vga_clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
      .DrawX(d0_x), .DrawY(d0_y), .hs(d0_hs), .vs(d0_vs),
      .active_nblank(d0_act), .frame_start(d0_fs), .frame_count(d0_fc)
   );

   // Closed-form expectation from the number of enabled edges since reset.
   function automatic exp_t model(input int ha, input int hf, input int hsw, input int hb,
                                  input int va, input int vf, input int vsw, input int vb,
                                  input int d, input int kk, input bit ce);
      exp_t e;
      int ht, vt, ft, p, q, qx, qy;
      ht   = ha + hf + hsw + hb;
      vt   = va + vf + vsw + vb;
      ft   = ht * vt;
      p    = kk % ft;
      e.x  = p % ht;
      e.y  = p / ht;
      e.fc = (kk / ft) % 65536;
      e.fs = (p == 0 && ce) ? 1 : 0;
      if (kk < d) begin
         e.hs = 1; e.vs = 1; e.act = 0;
      end else begin
         q  = (kk - d) % ft;
         qx = q % ht;
         qy = q / ht;
         e.hs  = (qx >= ha + hf && qx < ha + hf + hsw) ? 0 : 1;
         e.vs  = (qy >= va + vf && qy < va + vf + vsw) ? 0 : 1;
         e.act = (qx < ha && qy < va) ? 1 : 0;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s k=%0d: got %0d want %0d", tag, k, obs, expv);
      end
   endtask

   task automatic push_all();
      q_def.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 1, k, pix_ce));
      q_d3.push_back(model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 3, k, pix_ce));
      q_d0.push_back(model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 0, k, pix_ce));
   endtask

   task automatic pop_check_all();
      exp_t e;
      e = q_def.pop_front();
      chk("def_x", int'(def_x), e.x);    chk("def_y", int'(def_y), e.y);
      chk("def_hs", int'(def_hs), e.hs); chk("def_vs", int'(def_vs), e.vs);
      chk("def_act", int'(def_act), e.act); chk("def_fs", int'(def_fs), e.fs);
      chk("def_fc", int'(def_fc), e.fc);
      e = q_d3.pop_front();
      chk("d3_x", int'(d3_x), e.x);    chk("d3_y", int'(d3_y), e.y);
      chk("d3_hs", int'(d3_hs), e.hs); chk("d3_vs", int'(d3_vs), e.vs);
      chk("d3_act", int'(d3_act), e.act); chk("d3_fs", int'(d3_fs), e.fs);
      chk("d3_fc", int'(d3_fc), e.fc);
      e = q_d0.pop_front();
      chk("d0_x", int'(d0_x), e.x);    chk("d0_y", int'(d0_y), e.y);
      chk("d0_hs", int'(d0_hs), e.hs); chk("d0_vs", int'(d0_vs), e.vs);
      chk("d0_act", int'(d0_act), e.act); chk("d0_fs", int'(d0_fs), e.fs);
      chk("d0_fc", int'(d0_fc), e.fc);
   endtask

   // One clock: drive at the falling edge, predict, compare just after the rising edge.
   task automatic step(input bit rst, input bit ce);
      @(negedge clk);
      reset_n = rst;
      pix_ce  = ce;
      if (!rst) k = 0;
      else if (ce) k++;
      push_all();
      @(posedge clk);
      #1;
      pop_check_all();
   endtask

   // Reset asserted between edges must show up without any clock edge.
   task automatic async_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      k = 0;
      push_all();
      #1;
      pop_check_all();
   endtask

   int  hs_low_cnt;
   int  hs_first_low;
   int  vs_low_cnt;
   int  d3_rise_k;
   int  d0_rise_k;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n      = 1'b0;
      pix_ce       = 1'b1;
      hs_low_cnt   = 0;
      hs_first_low = -1;
      vs_low_cnt   = 0;
      d3_rise_k    = -1;
      d0_rise_k    = -1;

      repeat (3) step(1'b0, 1'b1);
      if (d0_act) d0_rise_k = 0;

      for (int i = 0; i < 1700; i++) begin
         step(1'b1, 1'b1);
         if (k >= 1 && k <= 800 && !def_hs) begin
            hs_low_cnt++;
            if (hs_first_low < 0) hs_first_low = k;
         end
         if (k >= 1 && k <= 48 && !d3_vs) vs_low_cnt++;
         if (d3_rise_k < 0 && d3_act) d3_rise_k = k;
         if (d0_rise_k < 0 && d0_act) d0_rise_k = k;
      end

      chk("hs_low_width", hs_low_cnt, 96);
      chk("hs_first_low", hs_first_low, 657);
      chk("d3_vs_low_width", vs_low_cnt, 8);
      chk("d3_act_rise", d3_rise_k, 3);
      chk("d0_act_rise", d0_rise_k, 0);

      for (int i = 0; i < 200; i++) step(1'b1, (i % 2) == 0);

      repeat (37) step(1'b1, 1'b1);
      async_reset();
      repeat (2) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      repeat (100) step(1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock, vga_clk, with every register updated on its rising edge.
REQ-002 The block SHALL use an asynchronous, active-low reset named reset_n.
REQ-003 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-004 Parameters H_FP, H_SYNC, H_BP SHALL default to 16, 96, 48: horizontal porches and sync width, in pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameters V_FP, V_SYNC, V_BP SHALL default to 10, 2, 33: vertical porches and sync width, in lines.
REQ-007 Parameter PIPE_DELAY, default 1, range 0..4: pixel-enabled stages of delay applied to hs, vs and active_nblank.
REQ-008 vga_clk  input  1: pixel clock.
REQ-009 reset_n  input  1: asynchronous active-low reset.
REQ-010 pix_ce  input  1: pixel clock enable; when low, all state holds.
REQ-011 DrawX  output  10: current horizontal count, 0..H_TOTAL-1.
REQ-012 DrawY  output  10: current vertical count, 0..V_TOTAL-1.
REQ-013 hs  output  1: horizontal sync, active low, delayed by PIPE_DELAY.
REQ-014 vs  output  1: vertical sync, active low, delayed by PIPE_DELAY.
REQ-015 active_nblank  output  1: high when the pixel is visible, delayed by PIPE_DELAY.
REQ-016 frame_start  output  1: one-enabled-cycle pulse at DrawX=0, DrawY=0, undelayed.
REQ-017 frame_count  output  16: number of completed frames, wrapping.

Function
REQ-018 The block SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-019 On each cycle with pix_ce=1, DrawX SHALL increment, and at H_TOTAL-1 it SHALL wrap to 0.
REQ-020 DrawY SHALL increment only on a cycle where pix_ce=1 and DrawX=H_TOTAL-1.
REQ-021 When that DrawX wrap coincides with DrawY=V_TOTAL-1, DrawY SHALL wrap to 0 and frame_count SHALL increment.
REQ-022 frame_count SHALL wrap from 16'hFFFF to 0.
REQ-023 The raw hs SHALL be 0 exactly when H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-024 The raw vs SHALL be 0 exactly when V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-025 The raw active SHALL be 1 exactly when DrawX < H_ACTIVE and DrawY < V_ACTIVE.
REQ-026 Each delayed output SHALL be its raw value passed through PIPE_DELAY registers, with each register advancing only when pix_ce=1.
REQ-027 When PIPE_DELAY=0, hs, vs and active_nblank SHALL be combinational decodes of the registered counters.
REQ-028 PIPE_DELAY=1 SHALL align the outputs with the one-cycle pixel colour register of the sprite stage downstream.
REQ-029 frame_start SHALL be a combinational decode: (DrawX==0 && DrawY==0 && pix_ce).
REQ-030 When pix_ce=0, the counters, the delay pipeline and frame_count SHALL hold their values, and frame_start SHALL be 0.
REQ-031 The block SHALL require a pixel clock but SHALL NOT require any handshake from downstream; consumers sample on the enabled cycles.

Reset
REQ-032 While reset_n=0, DrawX=0, DrawY=0 and frame_count=0.
REQ-033 While reset_n=0, every delay register SHALL be at its inactive value: hs=1, vs=1, active_nblank=0.
REQ-034 Reset asserted mid-frame SHALL take effect immediately, with no completion of the line.
REQ-035 On the first enabled cycle after reset_n rises, DrawX SHALL become 1.
REQ-036 After reset, frame_start SHALL first assert on the first cycle where pix_ce=1, since the counters sit at 0,0.

Structure
REQ-037 A shared package vga_pkg SHALL hold the timing defaults (H_*/V_* values, H_TOTAL, V_TOTAL) and the 10-bit coordinate typedef coord_t.
REQ-038 The block SHALL contain one sub-module, sync_delay: a parameterised, enable-gated shift register with a reset value, instantiated for hs, vs and active_nblank.

Verification
REQ-039 With reset held low for 3 cycles and pix_ce=1 afterwards: DrawX=0, DrawY=0, hs=1, vs=1, active_nblank=0 during reset, and DrawX=1 one cycle after release.
REQ-040 With pix_ce=1 for 800 cycles from reset: hs=0 for exactly 96 consecutive cycles starting PIPE_DELAY cycles after DrawX=656, and DrawY=1 after DrawX wraps from 799.
REQ-041 With pix_ce=1 for a full frame (420000 cycles): frame_count=1, frame_start pulsed twice (at cycle 0 and cycle 420000), and vs low for 1600 cycles.
REQ-042 With pix_ce toggling 1,0,1,0: DrawX advances every other cycle, and a frame takes 840000 cycles.
REQ-043 With reset_n pulsed low at DrawX=300, DrawY=200: all outputs go to reset values within the same cycle, with no wait for a clock edge.
REQ-044 A bench sweep over PIPE_DELAY=0 and 3 SHALL show the active_nblank rising edge occurring 0 or 3 enabled cycles after DrawX=0 on line 0.
